// File: rtl/multicycle_datapath.sv
// Multi-cycle ARM-subset datapath: PC, IR, register file, extender and ALU sequenced through
// FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes. PERF_CNT_EN adds cycle/instruction counters.
module multicycle_datapath #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int MEM_DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic [1:0]        RegSrc,
    input  logic [1:0]        ImmSrc,
    input  logic              ALUSrc,
    input  logic              PCSrc,
    input  logic [3:0]        ALUControl,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [WIDTH-1:0]  pc,
    output logic [31:0]       instruction,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WIDTH-1:0]  dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    input  logic [MEM_DW-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [3:0]        ALUFlags,
    output logic              instr_done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [3:0] PC_IDX = 4'(NREGS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wd_q, wd_d;
    logic [WIDTH-1:0] alu_q, alu_d, load_q, load_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] rf_val [NREGS-1];
    logic [WIDTH-1:0] pc_plus4, pc_plus8;
    logic [3:0]       ra1, ra2, rd_idx;
    logic [WIDTH-1:0] rd1, rd2, rd3;
    logic [WIDTH-1:0] ext_imm, src_b, alu_res, result;
    logic [WIDTH:0]   sum, diff;
    logic             alu_c, alu_v;
    logic             is_load, rf_we;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign pc_plus8 = pc_q + WIDTH'(8);
    assign rd_idx   = ir_q[15:12];
    // Both control bits set is a store, so the load path is only taken for a pure load.
    assign is_load  = MemtoReg & ~MemWrite;
    assign result   = is_load ? load_q : alu_q;

    always_comb begin
        ra1 = RegSrc[0] ? PC_IDX : ir_q[19:16];
        ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
        rd1 = (ra1 == PC_IDX) ? pc_plus8 : '0;
        rd2 = (ra2 == PC_IDX) ? pc_plus8 : '0;
        rd3 = (rd_idx == PC_IDX) ? pc_plus8 : '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            if (ra1 == 4'(i))    rd1 = rf_val[i];
            if (ra2 == 4'(i))    rd2 = rf_val[i];
            if (rd_idx == 4'(i)) rd3 = rf_val[i];
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS - 1; gi++) begin : g_rf
            logic [WIDTH-1:0] r_q, r_d;
            always_comb begin
                r_d = r_q;
                if (rf_we && rd_idx == 4'(gi)) r_d = result;
            end
            always_ff @(posedge clk) begin
                if (rst) r_q <= '0;
                else     r_q <= r_d;
            end
            assign rf_val[gi] = r_q;
        end
    endgenerate

    always_comb begin
        case (ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
            2'b10:   ext_imm = {{(WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        src_b   = ALUSrc ? ext_imm : b_q;
        sum     = {1'b0, a_q} + {1'b0, src_b};
        // Subtract as A + ~B + 1 so the carry out reads as "no borrow".
        diff    = {1'b0, a_q} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            4'b0000: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'b0001: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a_q[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'b0010: alu_res = a_q & src_b;
            4'b0011: alu_res = a_q | src_b;
            4'b0100: alu_res = a_q ^ src_b;
            4'b0101: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        wd_d    = wd_q;
        alu_d   = alu_q;
        load_d  = load_q;
        flags_d = flags_q;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                wd_d    = rd3;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d   = alu_res;
                flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                state_d = (MemtoReg | MemWrite) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_load) load_d = WIDTH'(dmem_rdata);
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = RegWrite && (rd_idx != PC_IDX);
                pc_d    = (PCSrc || (RegWrite && rd_idx == PC_IDX)) ? result : pc_plus4;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            alu_q   <= '0;
            load_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            alu_q   <= alu_d;
            load_q  <= load_d;
            flags_q <= flags_d;
        end
    end

    // imem_req is masked while rst is held so a fetch never appears during reset.
    assign imem_req    = (state_q == S_FETCH) & ~rst;
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = dmem_req & MemWrite;
    assign dmem_addr   = alu_q;
    assign dmem_wdata  = wd_q;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign ALUFlags    = flags_q;
    assign instr_done  = (state_q == S_WB);

    logic unused_ir;
    assign unused_ir = &{1'b0, ir_q[31:24]};

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q + (instr_done ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
